// File: rtl/cp0_timer_pkg.sv
// -----------------------------------------------------------------------------
// cp0_timer_pkg
//   Shared constants for the coprocessor-0 count/compare timer: the cp0 bus
//   addresses it decodes, the ctl register layout and a helper that maps a
//   compare channel index onto its bus address.
//
//   Address map
//     CP0_COUNT     (9)        count register
//     CP0_COMPARE   (11)       compare channel 0
//     CP0_COMPARE_X (21) + K   compare channel K, K = 1..NCMP-1
//     CP0_TIMERCTL  (25)       ctl: [NCMP-1:0] channel enable, [31] freeze
// -----------------------------------------------------------------------------
package cp0_timer_pkg;

    localparam int DATA_W = 64;

    localparam logic [4:0] CP0_COUNT     = 5'd9;
    localparam logic [4:0] CP0_COMPARE   = 5'd11;
    localparam logic [4:0] CP0_COMPARE_X = 5'd21;
    localparam logic [4:0] CP0_TIMERCTL  = 5'd25;

    localparam int CTL_FREEZE = 31;

    // Channel 0 keeps the legacy compare address; the extra channels sit in
    // a contiguous block above CP0_COMPARE_X.
    function automatic logic [4:0] cmp_addr(input int k);
        if (k == 0) begin
            return CP0_COMPARE;
        end
        return CP0_COMPARE_X + 5'(k);
    endfunction

endpackage

// File: rtl/cp0_timer_chan.sv
// -----------------------------------------------------------------------------
// cp0_timer_chan
//   One compare channel of the cp0 timer. Holds the compare value and the
//   match-pending flag.
//
//   Ports
//     clk         in   system clock
//     rst         in   asynchronous, active-high reset
//     count_next  in   W   value the count register is loaded with this cycle
//     count_load  in   1   count register loads count_next this cycle
//                          (already qualified with phi2)
//     cmp_we      in   1   compare write for this channel (phi2-qualified)
//     wdata       in   W   compare write data
//     cmp         out  W   current compare value
//     pending     out  1   match pending
//
//   A match is an event, not a level: pending only sets in the cycle the
//   count register is loaded with a value equal to cmp. Sitting at the
//   compare value (e.g. while frozen) never re-arms it, and rewriting cmp to
//   the current count does not trigger it either because no load happens.
// -----------------------------------------------------------------------------
module cp0_timer_chan
    import cp0_timer_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] count_next,
    input  logic         count_load,
    input  logic         cmp_we,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] cmp,
    output logic         pending
);

    logic match;

    // Compared against the cmp value held before any same-cycle write.
    assign match = count_load && (count_next == cmp);

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values; = here would let cmp update before match is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp     <= '1;
            pending <= 1'b0;
        end else if (cmp_we) begin
            // A compare write acknowledges the channel and wins over a
            // match arriving in the same cycle.
            cmp     <= wdata;
            pending <= 1'b0;
        end else if (match) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer
//   Parametrised count/compare timer for the cp0 register file. A prescaled
//   up-counter is compared against NCMP compare registers; each channel
//   latches a pending bit on the match edge and raises irq when enabled.
//
//   Parameters
//     W     counter / compare width (1..64)
//     DIV   phi2 cycles per count increment (>= 1)
//     NCMP  number of compare channels (1..4)
//
//   Ports
//     clk      in   1     system clock
//     rst      in   1     asynchronous, active-high reset
//     phi2     in   1     phase enable; state only changes when phi2 = 1
//     raddr    in   5     cp0 read address
//     rdata    out  64    read data, combinational, zero-extended
//     waddr    in   5     cp0 write address
//     wdata    in   64    write data
//     write    in   1     write strobe, sampled when phi2 = 1
//     count    out  W     current counter value
//     pending  out  NCMP  per-channel match pending
//     irq      out  NCMP  pending & enable
//     irq_any  out  1     OR of irq
// -----------------------------------------------------------------------------
module cp0_timer
    import cp0_timer_pkg::*;
#(
    parameter int W    = 32,
    parameter int DIV  = 2,
    parameter int NCMP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              phi2,
    input  logic [4:0]        raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              write,
    output logic [W-1:0]      count,
    output logic [NCMP-1:0]   pending,
    output logic [NCMP-1:0]   irq,
    output logic              irq_any
);

    // DIV = 1 still gets a one-bit prescaler that simply stays at 0, which
    // makes every phi2 cycle a tick without a special case.
    localparam int             PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0]   presc;
    logic [NCMP-1:0] enable;
    logic            freeze;

    logic            count_we;
    logic            ctl_we;
    logic [NCMP-1:0] cmp_we;
    logic            tick;
    logic            count_load;
    logic [W-1:0]    count_next;
    logic [W-1:0]    cmp_q [NCMP];
    logic [DATA_W-1:0] ctl_word;

    // Only the low W / NCMP bits and the freeze bit of wdata are stored.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    assign count_we = phi2 && write && (waddr == CP0_COUNT);
    assign ctl_we   = phi2 && write && (waddr == CP0_TIMERCTL);

    // ------------------------------------------------------------------
    // Prescaler and counter
    // ------------------------------------------------------------------
    assign tick       = phi2 && !freeze && (presc == PRESC_LAST);
    assign count_load = count_we || tick;
    // A software count write overrides the tick increment.
    assign count_next = count_we ? wdata[W-1:0] : count + W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            presc <= '0;
        end else if (phi2) begin
            if (count_load) begin
                count <= count_next;
            end
            // Restart the prescale phase on a count write so the new value
            // lasts a full DIV cycles, regardless of freeze.
            if (count_we || tick) begin
                presc <= '0;
            end else if (!freeze) begin
                presc <= presc + PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Control register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable <= NCMP'(1);
            freeze <= 1'b0;
        end else if (ctl_we) begin
            enable <= wdata[NCMP-1:0];
            freeze <= wdata[CTL_FREEZE];
        end
    end

    // ------------------------------------------------------------------
    // Compare channels
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NCMP; k++) begin : g_chan
        assign cmp_we[k] = phi2 && write && (waddr == cmp_addr(k));

        cp0_timer_chan #(
            .W (W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .count_next (count_next),
            .count_load (count_load),
            .cmp_we     (cmp_we[k]),
            .wdata      (wdata[W-1:0]),
            .cmp        (cmp_q[k]),
            .pending    (pending[k])
        );
    end

    // ------------------------------------------------------------------
    // Interrupts: straight from registered state, no added latency.
    // ------------------------------------------------------------------
    assign irq     = pending & enable;
    assign irq_any = |irq;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    // NOTE: every signal driven from always_comb gets a full default first,
    // otherwise unmatched addresses would infer a latch.
    always_comb begin
        ctl_word             = '0;
        ctl_word[NCMP-1:0]   = enable;
        ctl_word[CTL_FREEZE] = freeze;
    end

    always_comb begin
        rdata = '0;
        if (raddr == CP0_COUNT) begin
            rdata = DATA_W'(count);
        end else if (raddr == CP0_TIMERCTL) begin
            rdata = ctl_word;
        end
        // Compare addresses never alias count or ctl.
        for (int k = 0; k < NCMP; k++) begin
            if (raddr == cmp_addr(k)) begin
                rdata = DATA_W'(cmp_q[k]);
            end
        end
    end

endmodule

// File: tb/tb_cp0_timer.sv
// -----------------------------------------------------------------------------
// tb_cp0_timer
//   Directed bench for cp0_timer with W=32, DIV=2, NCMP=2. phi2 is held high
//   throughout, so the count advances once every two clk cycles. Inputs are
//   driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_cp0_timer;

    localparam int W    = 32;
    localparam int DIV  = 2;
    localparam int NCMP = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            phi2;
    logic [4:0]      raddr;
    logic [63:0]     rdata;
    logic [4:0]      waddr;
    logic [63:0]     wdata;
    logic            write;
    logic [W-1:0]    count;
    logic [NCMP-1:0] pending;
    logic [NCMP-1:0] irq;
    logic            irq_any;

    int n_cmp = 0;
    int n_err = 0;

    cp0_timer #(
        .W    (W),
        .DIV  (DIV),
        .NCMP (NCMP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .phi2    (phi2),
        .raddr   (raddr),
        .rdata   (rdata),
        .waddr   (waddr),
        .wdata   (wdata),
        .write   (write),
        .count   (count),
        .pending (pending),
        .irq     (irq),
        .irq_any (irq_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges (n >= 1), ending 1 unit after the last edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle write strobe.
    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        waddr = a;
        wdata = d;
        write = 1'b1;
        cycles(1);
        write = 1'b0;
        waddr = 5'd0;
        wdata = 64'd0;
    endtask

    initial begin
        rst   = 1'b1;
        phi2  = 1'b1;
        write = 1'b0;
        raddr = 5'd0;
        waddr = 5'd0;
        wdata = 64'd0;

        // ---------------- reset state ----------------
        #1;
        check("rst_count",   64'(count),   64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_irq",     64'(irq),     64'd0);
        check("rst_irq_any", 64'(irq_any), 64'd0);
        raddr = 5'd11; #1;
        check("rst_cmp0", rdata, 64'h0000_0000_FFFF_FFFF);
        raddr = 5'd25; #1;
        check("rst_ctl", rdata, 64'h1);

        @(posedge clk); #1;
        rst = 1'b0;

        // ---------------- free run: 10 cycles -> count 5 ----------------
        cycles(10);
        check("run10_count", 64'(count), 64'd5);
        raddr = 5'd9; #1;
        check("rd_count", rdata, 64'h5);
        raddr = 5'd11; #1;
        check("rd_cmp0", rdata, 64'h0000_0000_FFFF_FFFF);

        // ---------------- cmp0 = 8 match ----------------
        wr(5'd11, 64'd8);                       // count 5, prescaler 0 -> 1
        check("cmpw_count", 64'(count), 64'd5);
        cycles(4);
        check("pre8_count",   64'(count),   64'd7);
        check("pre8_pending", 64'(pending), 64'd0);
        cycles(1);
        check("at8_count",   64'(count),   64'd8);
        check("at8_pending", 64'(pending), 64'b01);
        check("at8_irq",     64'(irq),     64'b01);
        check("at8_irq_any", 64'(irq_any), 64'd1);

        // ---------------- freeze at 8 ----------------
        wr(5'd25, 64'h8000_0001);
        cycles(20);
        check("frz_count",   64'(count),   64'd8);
        check("frz_pending", 64'(pending), 64'b01);
        raddr = 5'd25; #1;
        check("frz_ctl", rdata, 64'h8000_0001);

        // Rewriting cmp0 to the held count clears and does not re-set.
        wr(5'd11, 64'd8);
        check("clr_pending", 64'(pending), 64'd0);
        cycles(5);
        check("clr_hold_pending", 64'(pending), 64'd0);
        check("clr_hold_count",   64'(count),   64'd8);

        // ---------------- disabled channel 1 still latches ----------------
        wr(5'd22, 64'd3);
        wr(5'd9,  64'd0);
        wr(5'd25, 64'h1);                       // unfreeze, enable = 01
        check("ch1_start_count", 64'(count), 64'd0);
        cycles(5);
        check("ch1_pre_count",   64'(count),   64'd2);
        check("ch1_pre_pending", 64'(pending), 64'd0);
        cycles(1);
        check("ch1_count",   64'(count),   64'd3);
        check("ch1_pending", 64'(pending), 64'b10);
        check("ch1_irq",     64'(irq),     64'b00);
        check("ch1_irq_any", 64'(irq_any), 64'd0);
        wr(5'd25, 64'h3);
        check("ch1_en_irq",     64'(irq),     64'b10);
        check("ch1_en_irq_any", 64'(irq_any), 64'd1);

        // ---------------- wrap-around match on cmp0 = 0 ----------------
        wr(5'd9, 64'hFFFF_FFFE);
        check("wrap_load", 64'(count), 64'hFFFF_FFFE);
        wr(5'd11, 64'd0);
        cycles(2);
        check("wrap_ff_count",   64'(count),   64'hFFFF_FFFF);
        check("wrap_ff_pending", 64'(pending), 64'b10);
        cycles(1);
        check("wrap_count",   64'(count),   64'd0);
        check("wrap_pending", 64'(pending), 64'b11);
        check("wrap_irq",     64'(irq),     64'b11);

        // ---------------- cmp write beats same-cycle match ----------------
        wr(5'd11, 64'd1);                       // prescaler 0 -> 1, no tick
        check("cb_setup_pending", 64'(pending), 64'b10);
        wr(5'd11, 64'h55);                      // tick loads 1 == old cmp0
        check("cb_count",   64'(count),   64'd1);
        check("cb_pending", 64'(pending), 64'b10);
        raddr = 5'd11; #1;
        check("cb_cmp0", rdata, 64'h55);

        // ---------------- count write beats same-cycle tick ----------------
        cycles(1);                              // prescaler now at DIV-1
        wr(5'd9, 64'd100);
        check("cw_count", 64'(count), 64'd100);
        cycles(1);
        check("cw_hold", 64'(count), 64'd100);
        cycles(1);
        check("cw_inc", 64'(count), 64'd101);

        // cmp written equal to current count: no set.
        wr(5'd11, 64'd101);
        check("cmpeq_pending", 64'(pending), 64'b10);
        raddr = 5'd5; #1;
        check("rd_unmapped", rdata, 64'd0);

        // Count write equal to cmp0 is a load, so it does set.
        wr(5'd9, 64'd101);
        check("cwm_count",   64'(count),   64'd101);
        check("cwm_pending", 64'(pending), 64'b11);
        check("cwm_irq_any", 64'(irq_any), 64'd1);
        cycles(1);                              // mid-prescale
        check("mid_count", 64'(count), 64'd101);

        // ---------------- asynchronous reset, no clock edge ----------------
        #2;
        rst = 1'b1;
        #1;
        check("arst_count",   64'(count),   64'd0);
        check("arst_pending", 64'(pending), 64'd0);
        check("arst_irq",     64'(irq),     64'd0);
        check("arst_irq_any", 64'(irq_any), 64'd0);
        raddr = 5'd11; #1;
        check("arst_cmp0", rdata, 64'h0000_0000_FFFF_FFFF);

        @(posedge clk); #1;
        rst = 1'b0;
        cycles(2);
        check("post_rst_count", 64'(count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
